ieeedrv_sector_xfer: RTL and testbench

- Controller-side sector transfer engine for the IEEE drive emulation; the other end of the track generator's byte interface.
- Given a job (track, sector, read or write), it follows the serial byte stream (sync, header, data). It locates the matching header and either captures 256 data bytes into a sector buffer or writes 256 bytes plus checksum back through the write path.
- Sits between the drive DOS/job logic and the track generator.

---
 rtl/ieeedrv_pkg.sv | 30 +++
 rtl/ieeedrv_byte_xor_acc.sv | 26 ++
 rtl/ieeedrv_sector_xfer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ieeedrv_sector_xfer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieeedrv_pkg.sv
// Shared types and constants for the IEEE drive controller-side sector engine.
package ieeedrv_pkg;

  localparam logic [7:0] HEADER_SYNC_CODE = 8'h08;
  localparam logic [7:0] DATA_SYNC_CODE   = 8'h07;
  localparam logic [7:0] TEST_SYNC_CODE   = 8'h0F;

  typedef enum logic [2:0] {
    JS_OK        = 3'd0,
    JS_NOT_FOUND = 3'd1,
    JS_HDR_CHK   = 3'd2,
    JS_DATA_CHK  = 3'd3,
    JS_WPROT     = 3'd4,
    JS_NO_DISK   = 3'd5
  } job_status_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HUNT,
    S_CODE,
    S_HDR,
    S_DSYNC,
    S_DCODE,
    S_RDATA,
    S_WGAP,
    S_WSYNC,
    S_WDATA
  } state_e;

endpackage

// File: rtl/ieeedrv_byte_xor_acc.sv
// Byte-wide XOR checksum accumulator; clear has priority over enable.
module ieeedrv_byte_xor_acc (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q ^ din;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/ieeedrv_sector_xfer.sv
// Sector transfer engine: finds a track/sector header in the byte stream and
// reads the 256-byte data block into a buffer or writes it back with checksum.
module ieeedrv_sector_xfer
  import ieeedrv_pkg::*;
#(
  parameter int unsigned HDR_TIMEOUT   = 64,
  parameter int unsigned SYNC_WR_BYTES = 3,
  parameter int unsigned WR_GAP_BYTES  = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        job_start,
  input  logic        job_write,
  input  logic [7:0]  job_track,
  input  logic [4:0]  job_sector,
  output logic        job_busy,
  output logic        job_done,
  output logic [2:0]  job_status,
  output logic [15:0] hdr_id,
  output logic [7:0]  buf_addr,
  output logic        buf_we,
  output logic [7:0]  buf_wdata,
  input  logic [7:0]  buf_rdata,
  input  logic        wprot,
  input  logic        byte_n,
  input  logic        sync_rd_n,
  input  logic [7:0]  byte_rd,
  input  logic        error,
  output logic        rw,
  output logic        sync_wr,
  output logic [7:0]  byte_wr
);

  localparam logic [8:0] HDR_LAST  = 9'(HDR_TIMEOUT - 1);
  localparam logic [8:0] GAP_LAST  = 9'(WR_GAP_BYTES - 1);
  localparam logic [8:0] SYNC_LAST = 9'(SYNC_WR_BYTES - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d, hdr_cnt_q, hdr_cnt_d;
  logic [7:0]  job_trk_q, job_trk_d;
  logic [4:0]  job_sec_q, job_sec_d;
  logic        job_wr_q, job_wr_d;
  logic [7:0]  hdr_chk_q, hdr_chk_d, hdr_sec_q, hdr_sec_d, hdr_trk_q, hdr_trk_d, idh_q, idh_d;
  logic        job_busy_q, job_busy_d, job_done_q, job_done_d;
  job_status_e job_status_q, job_status_d;
  logic [15:0] hdr_id_q, hdr_id_d;
  logic [7:0]  buf_addr_q, buf_addr_d, buf_wdata_q, buf_wdata_d, byte_wr_q, byte_wr_d;
  logic        buf_we_q, buf_we_d, rw_q, rw_d, sync_wr_q, sync_wr_d;

  logic        strobe, fin, hdr_match, hdr_good;
  job_status_e fin_status;
  logic        acc_clr, acc_en;
  logic [7:0]  acc_din, chk;

  assign strobe = ~byte_n;

  ieeedrv_byte_xor_acc u_chk (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (acc_clr),
    .en      (acc_en),
    .din     (acc_din),
    .acc     (chk)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hdr_cnt_q    <= '0;
      job_trk_q    <= '0;
      job_sec_q    <= '0;
      job_wr_q     <= 1'b0;
      hdr_chk_q    <= '0;
      hdr_sec_q    <= '0;
      hdr_trk_q    <= '0;
      idh_q        <= '0;
      job_busy_q   <= 1'b0;
      job_done_q   <= 1'b0;
      job_status_q <= JS_OK;
      hdr_id_q     <= '0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      buf_we_q     <= 1'b0;
      rw_q         <= 1'b1;
      sync_wr_q    <= 1'b0;
      byte_wr_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      job_trk_q    <= job_trk_d;
      job_sec_q    <= job_sec_d;
      job_wr_q     <= job_wr_d;
      hdr_chk_q    <= hdr_chk_d;
      hdr_sec_q    <= hdr_sec_d;
      hdr_trk_q    <= hdr_trk_d;
      idh_q        <= idh_d;
      job_busy_q   <= job_busy_d;
      job_done_q   <= job_done_d;
      job_status_q <= job_status_d;
      hdr_id_q     <= hdr_id_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      buf_we_q     <= buf_we_d;
      rw_q         <= rw_d;
      sync_wr_q    <= sync_wr_d;
      byte_wr_q    <= byte_wr_d;
    end
  end

  // At the id_lo strobe the accumulator holds sector^track^idh, so one more XOR completes it.
  always_comb begin
    state_d    = state_q;
    fin        = 1'b0;
    fin_status = JS_OK;
    hdr_match  = (hdr_sec_q == {3'b000, job_sec_q}) && (hdr_trk_q == job_trk_q);
    hdr_good   = ((chk ^ byte_rd) == hdr_chk_q);
    if (state_q != S_IDLE && error) begin
      fin        = 1'b1;
      fin_status = JS_NO_DISK;
    end else begin
      case (state_q)
        S_IDLE:
          if (job_start) begin
            if (job_write && wprot) begin
              fin        = 1'b1;
              fin_status = JS_WPROT;
            end else begin
              state_d = S_HUNT;
            end
          end
        S_HUNT:  if (!sync_rd_n) state_d = S_CODE;
        S_CODE:  if (strobe) state_d = (byte_rd == HEADER_SYNC_CODE) ? S_HDR : S_HUNT;
        S_HDR:
          if (strobe && cnt_q == 9'd4) begin
            if (hdr_match && !hdr_good) begin
              fin        = 1'b1;
              fin_status = JS_HDR_CHK;
            end else if (hdr_match) begin
              state_d = job_wr_q ? S_WGAP : S_DSYNC;
            end else if (hdr_cnt_q == HDR_LAST) begin
              fin        = 1'b1;
              fin_status = JS_NOT_FOUND;
            end else begin
              state_d = S_HUNT;
            end
          end
        S_DSYNC: if (!sync_rd_n) state_d = S_DCODE;
        S_DCODE:
          if (strobe) begin
            if (byte_rd == DATA_SYNC_CODE) state_d = S_RDATA;
            else begin
              fin        = 1'b1;
              fin_status = JS_NOT_FOUND;
            end
          end
        S_RDATA:
          if (strobe && cnt_q == 9'd256) begin
            fin        = 1'b1;
            fin_status = (byte_rd == chk) ? JS_OK : JS_DATA_CHK;
          end
        S_WGAP:  if (strobe && cnt_q == GAP_LAST) state_d = S_WSYNC;
        S_WSYNC: if (strobe && cnt_q == SYNC_LAST) state_d = S_WDATA;
        S_WDATA:
          if (strobe && cnt_q == 9'd257) begin
            fin        = 1'b1;
            fin_status = JS_OK;
          end
        default: state_d = S_IDLE;
      endcase
    end
    if (fin) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d        = cnt_q;
    hdr_cnt_d    = hdr_cnt_q;
    job_trk_d    = job_trk_q;
    job_sec_d    = job_sec_q;
    job_wr_d     = job_wr_q;
    hdr_chk_d    = hdr_chk_q;
    hdr_sec_d    = hdr_sec_q;
    hdr_trk_d    = hdr_trk_q;
    idh_d        = idh_q;
    job_busy_d   = job_busy_q;
    job_done_d   = 1'b0;
    job_status_d = job_status_q;
    hdr_id_d     = hdr_id_q;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    buf_we_d     = 1'b0;
    rw_d         = rw_q;
    sync_wr_d    = sync_wr_q;
    byte_wr_d    = byte_wr_q;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    acc_din      = byte_rd;
    case (state_q)
      S_IDLE:
        if (job_start) begin
          job_trk_d  = job_track;
          job_sec_d  = job_sector;
          job_wr_d   = job_write;
          hdr_cnt_d  = '0;
          job_busy_d = 1'b1;
        end
      S_CODE:
        if (strobe) begin
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      S_HDR:
        if (strobe) begin
          cnt_d = cnt_q + 9'd1;
          case (cnt_q)
            9'd0: hdr_chk_d = byte_rd;
            9'd1: begin hdr_sec_d = byte_rd; acc_en = 1'b1; end
            9'd2: begin hdr_trk_d = byte_rd; acc_en = 1'b1; end
            9'd3: begin idh_d     = byte_rd; acc_en = 1'b1; end
            default: begin
              cnt_d = '0;
              if (hdr_match && hdr_good) hdr_id_d = {idh_q, byte_rd};
              if (!hdr_match) hdr_cnt_d = hdr_cnt_q + 9'd1;
            end
          endcase
        end
      S_DCODE:
        if (strobe) begin
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      S_RDATA:
        if (strobe && !cnt_q[8]) begin
          buf_addr_d  = cnt_q[7:0];
          buf_wdata_d = byte_rd;
          buf_we_d    = 1'b1;
          acc_en      = 1'b1;
          cnt_d       = cnt_q + 9'd1;
        end
      S_WGAP:
        if (strobe) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == GAP_LAST) begin
            rw_d      = 1'b0;
            sync_wr_d = 1'b1;
            cnt_d     = '0;
          end
        end
      S_WSYNC:
        if (strobe) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == SYNC_LAST) begin
            sync_wr_d  = 1'b0;
            byte_wr_d  = DATA_SYNC_CODE;
            buf_addr_d = '0;
            acc_clr    = 1'b1;
            cnt_d      = '0;
          end
        end
      S_WDATA:
        // buf_rdata for address k settles two cycles after strobe k-1, well inside a byte period.
        if (strobe) begin
          cnt_d   = cnt_q + 9'd1;
          acc_din = buf_rdata;
          if (!cnt_q[8]) begin
            byte_wr_d = buf_rdata;
            acc_en    = 1'b1;
            if (cnt_q != 9'd255) buf_addr_d = buf_addr_q + 8'd1;
          end else if (cnt_q == 9'd256) begin
            byte_wr_d = chk;
          end
        end
      default: ;
    endcase
    if (fin) begin
      job_done_d   = 1'b1;
      job_status_d = fin_status;
      job_busy_d   = 1'b0;
      rw_d         = 1'b1;
      sync_wr_d    = 1'b0;
    end
  end

  assign job_busy   = job_busy_q;
  assign job_done   = job_done_q;
  assign job_status = job_status_q;
  assign hdr_id     = hdr_id_q;
  assign buf_addr   = buf_addr_q;
  assign buf_we     = buf_we_q;
  assign buf_wdata  = buf_wdata_q;
  assign rw         = rw_q;
  assign sync_wr    = sync_wr_q;
  assign byte_wr    = byte_wr_q;

endmodule

// File: tb/tb_ieeedrv_sector_xfer.sv
// Directed bench: a track generator model streams sync/header/data bytes and
// captures write-mode bytes; expected results are derived from the model's track.
module tb_ieeedrv_sector_xfer;
  import ieeedrv_pkg::*;

  localparam int BP   = 4;
  localparam int NSEC = 21;
  localparam logic [7:0] ID_H = 8'h41;
  localparam logic [7:0] ID_L = 8'h42;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        job_start = 1'b0, job_write = 1'b0;
  logic [7:0]  job_track = '0;
  logic [4:0]  job_sector = '0;
  logic        job_busy, job_done;
  logic [2:0]  job_status;
  logic [15:0] hdr_id;
  logic [7:0]  buf_addr, buf_wdata, buf_rdata;
  logic        buf_we;
  logic        wprot = 1'b0;
  logic        byte_n, sync_rd_n;
  logic [7:0]  byte_rd;
  logic        error = 1'b0;
  logic        rw, sync_wr;
  logic [7:0]  byte_wr;

  ieeedrv_sector_xfer #(.HDR_TIMEOUT(64), .SYNC_WR_BYTES(3), .WR_GAP_BYTES(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .job_start(job_start), .job_write(job_write),
    .job_track(job_track), .job_sector(job_sector), .job_busy(job_busy), .job_done(job_done),
    .job_status(job_status), .hdr_id(hdr_id), .buf_addr(buf_addr), .buf_we(buf_we),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .wprot(wprot), .byte_n(byte_n),
    .sync_rd_n(sync_rd_n), .byte_rd(byte_rd), .error(error), .rw(rw), .sync_wr(sync_wr),
    .byte_wr(byte_wr)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sector buffer: rbuf captures DUT writes, wbuf sources write jobs.
  logic [7:0] rbuf [256];
  logic [7:0] wbuf [256];
  int we_cnt = 0, done_cnt = 0, rw0_cnt = 0;

  always @(negedge clk_sys) begin
    if (buf_we) begin
      rbuf[buf_addr] = buf_wdata;
      we_cnt++;
    end
    if (job_done) done_cnt++;
    if (rw === 1'b0) rw0_cnt++;
  end

  always @(posedge clk_sys) buf_rdata <= wbuf[buf_addr];

  // Track generator model
  logic       gen_on = 1'b0;
  int         dlen = 256;
  logic [7:0] gtrack = 8'd5;
  int         bad_dchk_sec = -1, bad_hchk_sec = -1;
  int         hdr_sent = 0, wr_sync_cnt = 0;
  logic [7:0] wr_q [$];

  task automatic emit(input bit is_sync, input logic [7:0] b);
    while (gen_on && rw == 1'b0) begin
      byte_rd = 8'hFF;
      byte_n  = 1'b0;
      if (sync_wr) wr_sync_cnt++;
      else         wr_q.push_back(byte_wr);
      @(negedge clk_sys);
      byte_n = 1'b1;
      repeat (BP - 1) @(negedge clk_sys);
    end
    if (!gen_on) return;
    if (is_sync) begin
      sync_rd_n = 1'b0;
      repeat (BP) @(negedge clk_sys);
      sync_rd_n = 1'b1;
    end else begin
      byte_rd = b;
      byte_n  = 1'b0;
      @(negedge clk_sys);
      byte_n = 1'b1;
      repeat (BP - 1) @(negedge clk_sys);
    end
  endtask

  task automatic emit_sector(input int sn);
    logic [7:0] hchk, dchk, sb;
    sb   = 8'(sn);
    hchk = sb ^ gtrack ^ ID_H ^ ID_L;
    if (sn == bad_hchk_sec) hchk = hchk ^ 8'h01;
    emit(1, 8'h00); emit(1, 8'h00);
    emit(0, HEADER_SYNC_CODE); emit(0, hchk); emit(0, sb); emit(0, gtrack); emit(0, ID_H);
    if (gen_on) hdr_sent++;
    emit(0, ID_L);
    for (int g = 0; g < 4; g++) emit(0, 8'h55);
    emit(1, 8'h00); emit(1, 8'h00);
    emit(0, DATA_SYNC_CODE);
    dchk = 8'h00;
    for (int i = 0; i < dlen; i++) begin
      emit(0, 8'(i));
      dchk = dchk ^ 8'(i);
    end
    emit(0, (sn == bad_dchk_sec) ? (dchk ^ 8'hFF) : dchk);
    for (int g = 0; g < 4; g++) emit(0, 8'h55);
  endtask

  initial begin
    byte_n    = 1'b1;
    sync_rd_n = 1'b1;
    byte_rd   = 8'h00;
    forever begin
      wait (gen_on);
      hdr_sent    = 0;
      wr_sync_cnt = 0;
      wr_q.delete();
      // A foreign sync code first: the engine must ignore it and keep hunting.
      emit(1, 8'h00); emit(0, TEST_SYNC_CODE); emit(0, 8'h00); emit(0, 8'h00);
      while (gen_on)
        for (int sn = 0; sn < NSEC && gen_on; sn++) emit_sector(sn);
      @(negedge clk_sys);
    end
  end

  task automatic start_job(input logic wr, input logic [7:0] trk, input logic [4:0] sec);
    job_write  = wr;
    job_track  = trk;
    job_sector = sec;
    job_start  = 1'b1;
    @(negedge clk_sys);
    job_start = 1'b0;
    gen_on    = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20000 && !job_done; i++) @(negedge clk_sys);
    check(tag, 32'(job_done), 32'd1);
  endtask

  task automatic stop_gen();
    gen_on = 1'b0;
    repeat (3 * BP) @(negedge clk_sys);
  endtask

  initial begin
    int bad, snap, snap2;
    repeat (5) @(negedge clk_sys);
    check("rst_rw", 32'(rw), 32'd1);
    check("rst_busy_done", 32'({job_busy, job_done, buf_we, sync_wr}), 32'd0);
    check("rst_status", 32'(job_status), 32'd0);
    check("rst_addr_id_wr", 32'({buf_addr, hdr_id, byte_wr}), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Read sector 3 on track 5, data[i]=i
    snap = we_cnt;
    start_job(1'b0, 8'd5, 5'd3);
    wait_done("t1_done");
    check("t1_status", 32'(job_status), 32'(JS_OK));
    check("t1_hdr_id", 32'(hdr_id), 32'h4142);
    check("t1_busy", 32'(job_busy), 32'd0);
    stop_gen();
    bad = 0;
    for (int i = 0; i < 256; i++) if (rbuf[i] !== 8'(i)) bad++;
    check("t1_buf_bad", 32'(bad), 32'd0);
    check("t1_we_pulses", 32'(we_cnt - snap), 32'd256);

    // Sector 30 does not exist: NOT_FOUND after exactly 64 headers
    dlen = 4;
    start_job(1'b0, 8'd5, 5'd30);
    wait_done("t2_done");
    check("t2_status", 32'(job_status), 32'(JS_NOT_FOUND));
    check("t2_headers", 32'(hdr_sent), 32'd64);
    stop_gen();
    dlen = 256;

    // Corrupted data checksum
    bad_dchk_sec = 3;
    snap = we_cnt;
    start_job(1'b0, 8'd5, 5'd3);
    wait_done("t3_done");
    check("t3_status", 32'(job_status), 32'(JS_DATA_CHK));
    stop_gen();
    check("t3_we_pulses", 32'(we_cnt - snap), 32'd256);
    bad_dchk_sec = -1;

    // Corrupted header checksum on the wanted sector
    bad_hchk_sec = 3;
    start_job(1'b0, 8'd5, 5'd3);
    wait_done("t3b_done");
    check("t3b_status", 32'(job_status), 32'(JS_HDR_CHK));
    stop_gen();
    bad_hchk_sec = -1;

    // Write sector 7 on track 10 with A5 fill
    gtrack = 8'd10;
    for (int i = 0; i < 256; i++) wbuf[i] = 8'hA5;
    start_job(1'b1, 8'd10, 5'd7);
    wait_done("t4_done");
    check("t4_status", 32'(job_status), 32'(JS_OK));
    stop_gen();
    check("t4_rw", 32'(rw), 32'd1);
    check("t4_sync_periods", 32'(wr_sync_cnt), 32'd3);
    check("t4_nbytes", 32'(wr_q.size()), 32'd258);
    bad = 0;
    if (wr_q.size() >= 258) begin
      for (int i = 1; i <= 256; i++) if (wr_q[i] !== 8'hA5) bad++;
      check("t4_code", 32'(wr_q[0]), 32'h07);
      check("t4_chk", 32'(wr_q[257]), 32'h00);
    end else begin
      bad = 999;
    end
    check("t4_data_bad", 32'(bad), 32'd0);

    // Write-protected media
    wprot = 1'b1;
    snap  = rw0_cnt;
    start_job(1'b1, 8'd10, 5'd7);
    check("t5_done_next", 32'(job_done), 32'd1);
    check("t5_status", 32'(job_status), 32'(JS_WPROT));
    stop_gen();
    check("t5_rw_never0", 32'(rw0_cnt - snap), 32'd0);
    check("t5_busy", 32'(job_busy), 32'd0);
    wprot = 1'b0;

    // Media error in the middle of a read data block
    gtrack = 8'd5;
    snap   = we_cnt;
    start_job(1'b0, 8'd5, 5'd3);
    for (int i = 0; i < 20000 && (we_cnt - snap) < 100; i++) @(negedge clk_sys);
    check("t6a_in_rdata", 32'((we_cnt - snap) >= 100), 32'd1);
    error = 1'b1;
    @(negedge clk_sys);
    check("t6a_done_next", 32'(job_done), 32'd1);
    check("t6a_status", 32'(job_status), 32'(JS_NO_DISK));
    check("t6a_rw_sync", 32'({rw, sync_wr, job_busy}), 32'b100);
    error = 1'b0;
    stop_gen();

    // Reset in the middle of a write data block
    gtrack = 8'd10;
    start_job(1'b1, 8'd10, 5'd7);
    for (int i = 0; i < 20000 && wr_q.size() < 50; i++) @(negedge clk_sys);
    check("t6b_in_wdata", 32'(wr_q.size() >= 50), 32'd1);
    check("t6b_rw_low", 32'(rw), 32'd0);
    snap2 = done_cnt;
    reset = 1'b1;
    @(negedge clk_sys);
    check("t6b_rw", 32'(rw), 32'd1);
    check("t6b_flags", 32'({job_busy, job_done, buf_we, sync_wr}), 32'd0);
    check("t6b_status", 32'(job_status), 32'd0);
    check("t6b_addr_id_wr", 32'({buf_addr, hdr_id, byte_wr}), 32'd0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (50) @(negedge clk_sys);
    check("t6b_no_done", 32'(done_cnt - snap2), 32'd0);
    stop_gen();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
